rename_regfile: RTL and testbench

- Parametrised architectural register file with ROB-tag renaming, the next generation of the current decode-side register/tag table.
- Sits between decoder (operand read, destination rename), ROB (in-order commit, misbranch flush) and CDB (result broadcast).
- Additions over the current table:
  - N read ports.
  - Same-cycle CDB/commit bypass on reads.
  - Defined priority for simultaneous rename, commit and flush.
  - Busy-entry occupancy counter.

---
 rtl/rename_regfile_pkg.sv | 17 +
 rtl/rename_regfile_rdport.sv | 45 ++++
 rtl/rename_regfile.sv | 119 +++++++++++
 tb/tb_rename_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared constants for the rename register file: boolean levels, zero words, default widths.
// Latency/backpressure: n/a (constants only).
package rename_regfile_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int DEF_NUM_REGS  = 32;
   localparam int DEF_REG_IDX_W = 5;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ROB_TAG_W = 4;
   localparam int DEF_NUM_RD    = 2;

   localparam logic [DEF_DATA_W-1:0]    ZERO_DATA    = '0;
   localparam logic [DEF_ROB_TAG_W-1:0] ZERO_TAG_ROB = '0;

endpackage

// File: rtl/rename_regfile_rdport.sv
// Per-port operand read mux: x0 forcing, then same-cycle commit and CDB bypass over the table entry.
// Latency: combinational. Backpressure: none, a read is always answered.
module rename_regfile_rdport
   import rename_regfile_pkg::*;
#(
   parameter int REG_IDX_W = DEF_REG_IDX_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ROB_TAG_W = DEF_ROB_TAG_W
) (
   input  logic [REG_IDX_W-1:0] idx,
   input  logic [DATA_W-1:0]    ent_value,
   input  logic                 ent_busy,
   input  logic [ROB_TAG_W-1:0] ent_tag,
   input  logic                 cmt_valid,
   input  logic [REG_IDX_W-1:0] cmt_idx,
   input  logic [ROB_TAG_W-1:0] cmt_tag,
   input  logic [DATA_W-1:0]    cmt_value,
   input  logic                 cdb_valid,
   input  logic [ROB_TAG_W-1:0] cdb_tag,
   input  logic [DATA_W-1:0]    cdb_value,
   output logic [DATA_W-1:0]    rd_value,
   output logic [ROB_TAG_W-1:0] rd_tag,
   output logic                 rd_busy
);

   always_comb begin
      rd_value = ent_value;
      rd_tag   = '0;
      rd_busy  = FALSE;
      if (idx == '0) begin
         rd_value = '0;
      end else if (ent_busy) begin
         // Commit wins over CDB: it carries the architecturally final value.
         if (cmt_valid && (cmt_idx == idx) && (cmt_tag == ent_tag)) begin
            rd_value = cmt_value;
         end else if (cdb_valid && (cdb_tag == ent_tag)) begin
            rd_value = cdb_value;
         end else begin
            rd_busy = TRUE;
            rd_tag  = ent_tag;
         end
      end
   end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with ROB-tag renaming, N bypassed read ports and busy occupancy count.
// Latency: reads combinational, updates one cycle. Backpressure: rdy=0 freezes all state.
module rename_regfile
   import rename_regfile_pkg::*;
#(
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int REG_IDX_W = DEF_REG_IDX_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ROB_TAG_W = DEF_ROB_TAG_W,
   parameter int NUM_RD    = DEF_NUM_RD
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic [NUM_RD*REG_IDX_W-1:0]   rd_idx,
   output logic [NUM_RD*DATA_W-1:0]      rd_value,
   output logic [NUM_RD*ROB_TAG_W-1:0]   rd_tag,
   output logic [NUM_RD-1:0]             rd_busy,
   input  logic                          ren_valid,
   input  logic [REG_IDX_W-1:0]          ren_idx,
   input  logic [ROB_TAG_W-1:0]          ren_tag,
   input  logic                          cdb_valid,
   input  logic [ROB_TAG_W-1:0]          cdb_tag,
   input  logic [DATA_W-1:0]             cdb_value,
   input  logic                          cmt_valid,
   input  logic [REG_IDX_W-1:0]          cmt_idx,
   input  logic [ROB_TAG_W-1:0]          cmt_tag,
   input  logic [DATA_W-1:0]             cmt_value,
   input  logic                          flush,
   output logic [REG_IDX_W:0]            busy_count
);

   logic [DATA_W-1:0]    values [NUM_REGS];
   logic [ROB_TAG_W-1:0] tags   [NUM_REGS];
   logic [NUM_REGS-1:0]  busy;

   logic ren_we;
   logic cmt_we;
   logic cmt_clr;
   logic cnt_inc;
   logic cnt_dec;
   logic [REG_IDX_W:0] busy_count_nxt;

   assign ren_we  = ren_valid && (ren_idx != '0);
   assign cmt_we  = cmt_valid && (cmt_idx != '0);
   assign cmt_clr = cmt_we && busy[cmt_idx] && (tags[cmt_idx] == cmt_tag);

   // A same-cycle rename of the committing register keeps it busy, so no decrement then.
   assign cnt_inc = ren_we && !busy[ren_idx];
   assign cnt_dec = cmt_clr && !(ren_we && (ren_idx == cmt_idx));

   always_comb begin
      busy_count_nxt = busy_count;
      if (flush) begin
         busy_count_nxt = '0;
      end else begin
         busy_count_nxt = busy_count + {{REG_IDX_W{1'b0}}, cnt_inc}
                                     - {{REG_IDX_W{1'b0}}, cnt_dec};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            values[k] <= '0;
            tags[k]   <= '0;
         end
         busy       <= '0;
         busy_count <= '0;
      end else if (rdy) begin
         // The committing instruction is older than any flushing branch, so its value always lands.
         if (cmt_we) begin
            values[cmt_idx] <= cmt_value;
         end
         if (flush) begin
            busy <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
               tags[k] <= '0;
            end
         end else begin
            if (cmt_clr) begin
               busy[cmt_idx] <= FALSE;
            end
            if (ren_we) begin
               busy[ren_idx] <= TRUE;
               tags[ren_idx] <= ren_tag;
            end
         end
         busy_count <= busy_count_nxt;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [REG_IDX_W-1:0] idx;
      assign idx = rd_idx[p*REG_IDX_W +: REG_IDX_W];

      rename_regfile_rdport #(
         .REG_IDX_W (REG_IDX_W),
         .DATA_W    (DATA_W),
         .ROB_TAG_W (ROB_TAG_W)
      ) u_rdport (
         .idx       (idx),
         .ent_value (values[idx]),
         .ent_busy  (busy[idx]),
         .ent_tag   (tags[idx]),
         .cmt_valid (cmt_valid),
         .cmt_idx   (cmt_idx),
         .cmt_tag   (cmt_tag),
         .cmt_value (cmt_value),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_value (cdb_value),
         .rd_value  (rd_value[p*DATA_W +: DATA_W]),
         .rd_tag    (rd_tag[p*ROB_TAG_W +: ROB_TAG_W]),
         .rd_busy   (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: hand-computed expectations checked with immediate assertions.
module tb_rename_regfile;
   import rename_regfile_pkg::*;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic [9:0]  rd_idx;
   logic [63:0] rd_value;
   logic [7:0]  rd_tag;
   logic [1:0]  rd_busy;
   logic        ren_valid;
   logic [4:0]  ren_idx;
   logic [3:0]  ren_tag;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        cmt_valid;
   logic [4:0]  cmt_idx;
   logic [3:0]  cmt_tag;
   logic [31:0] cmt_value;
   logic        flush;
   logic [5:0]  busy_count;

   int vectors = 0;
   int errors  = 0;

   rename_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .rd_idx     (rd_idx),
      .rd_value   (rd_value),
      .rd_tag     (rd_tag),
      .rd_busy    (rd_busy),
      .ren_valid  (ren_valid),
      .ren_idx    (ren_idx),
      .ren_tag    (ren_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .cmt_valid  (cmt_valid),
      .cmt_idx    (cmt_idx),
      .cmt_tag    (cmt_tag),
      .cmt_value  (cmt_value),
      .flush      (flush),
      .busy_count (busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // Port 0 checks: value, busy, tag.
   task automatic chk0(input string name, input logic [31:0] v, input logic b, input logic [3:0] t);
      chk({name, ".val0"}, rd_value[31:0], v);
      chk({name, ".busy0"}, 32'(rd_busy[0]), 32'(b));
      chk({name, ".tag0"}, 32'(rd_tag[3:0]), 32'(t));
   endtask

   task automatic chk1(input string name, input logic [31:0] v, input logic b, input logic [3:0] t);
      chk({name, ".val1"}, rd_value[63:32], v);
      chk({name, ".busy1"}, 32'(rd_busy[1]), 32'(b));
      chk({name, ".tag1"}, 32'(rd_tag[7:4]), 32'(t));
   endtask

   task automatic chk_cnt(input string name, input logic [5:0] exp);
      chk({name, ".count"}, 32'(busy_count), 32'(exp));
   endtask

   task automatic idle();
      ren_valid = 1'b0; ren_idx = '0; ren_tag = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
      cmt_valid = 1'b0; cmt_idx = '0; cmt_tag = '0; cmt_value = '0;
      flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b);
      rd_idx = {b, a};
      #1;
   endtask

   task automatic ren(input logic [4:0] i, input logic [3:0] t);
      ren_valid = 1'b1; ren_idx = i; ren_tag = t;
      tick();
      idle();
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      rd_idx = '0;
      idle();

      // Reset state
      #12;
      rd(5'd5, 5'd0);
      chk0("rst_x5", ZERO_DATA, 1'b0, ZERO_TAG_ROB);
      chk1("rst_x0", ZERO_DATA, 1'b0, ZERO_TAG_ROB);
      chk_cnt("rst", 6'd0);
      rst = 1'b1;
      tick();

      // x0 rename is ignored
      ren(5'd0, 4'd3);
      rd(5'd0, 5'd0);
      chk0("ren_x0", 32'h0, 1'b0, 4'd0);
      chk_cnt("ren_x0", 6'd0);

      // Rename then commit x5
      ren(5'd5, 4'd2);
      rd(5'd5, 5'd0);
      chk0("ren_x5", 32'h0, 1'b1, 4'd2);
      chk_cnt("ren_x5", 6'd1);
      cmt_valid = 1'b1; cmt_idx = 5'd5; cmt_tag = 4'd2; cmt_value = 32'hDEAD;
      #1;
      chk0("cmt_byp_x5", 32'hDEAD, 1'b0, 4'd0);
      tick();
      idle();
      #1;
      chk0("cmt_x5", 32'hDEAD, 1'b0, 4'd0);
      chk_cnt("cmt_x5", 6'd0);

      // Stale commit leaves the newer rename in place
      ren(5'd5, 4'd2);
      ren(5'd5, 4'd7);
      chk_cnt("reren_x5", 6'd1);
      cmt_valid = 1'b1; cmt_idx = 5'd5; cmt_tag = 4'd2; cmt_value = 32'h11;
      #1;
      chk0("stale_byp_x5", 32'hDEAD, 1'b1, 4'd7);
      tick();
      idle();
      #1;
      chk0("stale_x5", 32'h11, 1'b1, 4'd7);
      chk_cnt("stale", 6'd1);

      // Commit zero register: no write
      cmt_valid = 1'b1; cmt_idx = 5'd0; cmt_tag = 4'd0; cmt_value = 32'hFF;
      tick();
      idle();
      rd(5'd0, 5'd0);
      chk0("cmt_x0", 32'h0, 1'b0, 4'd0);
      chk_cnt("cmt_x0", 6'd1);

      // Same-cycle commit and rename on x6
      ren(5'd6, 4'd1);
      chk_cnt("ren_x6", 6'd2);
      cmt_valid = 1'b1; cmt_idx = 5'd6; cmt_tag = 4'd1; cmt_value = 32'h22;
      ren_valid = 1'b1; ren_idx = 5'd6; ren_tag = 4'd4;
      tick();
      idle();
      rd(5'd6, 5'd5);
      chk0("cmtren_x6", 32'h22, 1'b1, 4'd4);
      chk1("cmtren_x5", 32'h11, 1'b1, 4'd7);
      chk_cnt("cmtren", 6'd2);

      // CDB bypass is read-only
      ren(5'd7, 4'd3);
      chk_cnt("ren_x7", 6'd3);
      cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h33;
      rd(5'd7, 5'd5);
      chk0("cdb_byp_x7", 32'h33, 1'b0, 4'd0);
      chk1("cdb_nobyp_x5", 32'h11, 1'b1, 4'd7);
      tick();
      idle();
      #1;
      chk0("cdb_after_x7", 32'h0, 1'b1, 4'd3);
      chk_cnt("cdb_after", 6'd3);

      // Fill x1..x4
      ren(5'd1, 4'd8);
      ren(5'd2, 4'd9);
      ren(5'd3, 4'd10);
      ren(5'd4, 4'd11);
      chk_cnt("fill", 6'd7);

      // Flush + rename + commit with rdy low: nothing changes
      rdy = 1'b0;
      flush = 1'b1;
      ren_valid = 1'b1; ren_idx = 5'd8; ren_tag = 4'd12;
      cmt_valid = 1'b1; cmt_idx = 5'd1; cmt_tag = 4'd0; cmt_value = 32'h44;
      tick();
      idle();
      rdy = 1'b1;
      rd(5'd1, 5'd8);
      chk0("frz_x1", 32'h0, 1'b1, 4'd8);
      chk1("frz_x8", 32'h0, 1'b0, 4'd0);
      chk_cnt("frz", 6'd7);

      // Same with rdy high: flush wins, commit value still lands
      flush = 1'b1;
      ren_valid = 1'b1; ren_idx = 5'd8; ren_tag = 4'd12;
      cmt_valid = 1'b1; cmt_idx = 5'd1; cmt_tag = 4'd0; cmt_value = 32'h44;
      tick();
      idle();
      rd(5'd1, 5'd8);
      chk0("flush_x1", 32'h44, 1'b0, 4'd0);
      chk1("flush_x8", 32'h0, 1'b0, 4'd0);
      rd(5'd5, 5'd6);
      chk0("flush_x5", 32'h11, 1'b0, 4'd0);
      chk1("flush_x6", 32'h22, 1'b0, 4'd0);
      chk_cnt("flush", 6'd0);

      // Asynchronous reset mid-operation
      ren(5'd9, 4'd5);
      chk_cnt("ren_x9", 6'd1);
      #2;
      rst = 1'b0;
      rd(5'd9, 5'd6);
      chk0("arst_x9", 32'h0, 1'b0, 4'd0);
      chk1("arst_x6", 32'h0, 1'b0, 4'd0);
      chk_cnt("arst", 6'd0);
      rst = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
